// File: rtl/Pipe_Buf_Reg_PKG.sv
// Shared types for the data-memory arbiter and the pipeline buffers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package Pipe_Buf_Reg_PKG;

    // Width of the external-requester starvation counter (holds 1..255).
    localparam int STARVE_CNT_W = 8;

    // ARB_CORE  : core has priority; the external requester is granted only
    //             in cycles where the core does not touch memory.
    // ARB_FORCE : the external requester has lost STARVE_LIMIT cycles in a
    //             row and is granted now, stalling the core if required.
    typedef enum logic [0:0] {
        ARB_CORE  = 1'b0,
        ARB_FORCE = 1'b1
    } arb_state_e;

endpackage

// File: rtl/dmem_starve_ctr.sv
// Starvation counter and force FSM for the data-memory arbiter.
// Latency: force_ext is registered; it rises the cycle after the LIMIT-th lost cycle.
// Backpressure: none; it counts the cycles in which the core blocks a pending external request.
//
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   ext_req      external request pending
//   core_act     core is reading or writing memory this cycle
//   ext_gnt      external request granted this cycle (from the top-level grant logic)
//   force_ext    external requester must be granted this cycle, even over the core
module dmem_starve_ctr
    import Pipe_Buf_Reg_PKG::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic ext_req,
    input  logic core_act,
    input  logic ext_gnt,
    output logic force_ext
);

    localparam logic [STARVE_CNT_W-1:0] LIMIT    = STARVE_CNT_W'(STARVE_LIMIT);
    localparam logic [STARVE_CNT_W-1:0] LIMIT_M1 = STARVE_CNT_W'(STARVE_LIMIT - 1);

    logic [STARVE_CNT_W-1:0] starve_cnt;
    arb_state_e              state_q;
    arb_state_e              state_d;
    logic                    lose;

    // A cycle is "lost" when the external side asks but the core keeps memory.
    assign lose = ext_req & core_act & ~ext_gnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (!ext_req || ext_gnt) begin
            starve_cnt <= '0;
        end else if (lose && (starve_cnt != LIMIT)) begin
            starve_cnt <= starve_cnt + STARVE_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ARB_CORE;
        end else begin
            state_q <= state_d;
        end
    end

    // The FSM enters ARB_FORCE on the same edge the counter reaches LIMIT, so
    // ARB_FORCE is equivalent to starve_cnt == LIMIT without needing the
    // comparator in the grant path.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARB_CORE: begin
                if (lose && (starve_cnt == LIMIT_M1)) begin
                    state_d = ARB_FORCE;
                end
            end
            ARB_FORCE: begin
                // A withdrawn request also leaves ARB_FORCE, matching the counter clear.
                if (ext_gnt || !ext_req) begin
                    state_d = ARB_CORE;
                end
            end
            default: state_d = ARB_CORE;
        endcase
    end

    assign force_ext = (state_q == ARB_FORCE);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single data-memory port between the MEM stage (priority) and an external requester.
// Latency: core access 0 cycles; ext write completes in its grant cycle; ext read data 1 cycle after grant.
// Backpressure: ext_req is held until the one-cycle ext_gnt; core_stall freezes the pipeline for a forced ext grant.
//
// Ports:
//   clk, reset                          clock and synchronous active-high reset
//   core_rd/wr/addr/wdata/funct3        MEM-stage access from the EX/MEM register
//   core_rdata                          load data to MEM/WB, straight from mem_rdata
//   core_stall                          freezes PC..EX/MEM and bubbles MEM/WB
//   ext_req/we/addr/wdata/funct3        external access, held until ext_gnt
//   ext_gnt, ext_rdata, ext_rvalid      grant pulse and registered read return
//   mem_rd/wr/addr/wdata/funct3         to datamemory
//   mem_rdata                           combinational read data from datamemory
//   perf_stall_cnt, perf_ext_cnt        present only when DMEM_ARB_PERF_EN is defined
//
// Optional feature: define DMEM_ARB_PERF_EN to add the two 32-bit performance counters.
module dmem_arbiter
    import Pipe_Buf_Reg_PKG::*;
#(
    parameter int DM_ADDRESS   = 9,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  core_rd,
    input  logic                  core_wr,
    input  logic [DM_ADDRESS-1:0] core_addr,
    input  logic [DATA_W-1:0]     core_wdata,
    input  logic [2:0]            core_funct3,
    output logic [DATA_W-1:0]     core_rdata,
    output logic                  core_stall,
    input  logic                  ext_req,
    input  logic                  ext_we,
    input  logic [DM_ADDRESS-1:0] ext_addr,
    input  logic [DATA_W-1:0]     ext_wdata,
    input  logic [2:0]            ext_funct3,
    output logic                  ext_gnt,
    output logic [DATA_W-1:0]     ext_rdata,
    output logic                  ext_rvalid,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [DM_ADDRESS-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [2:0]            mem_funct3,
    input  logic [DATA_W-1:0]     mem_rdata
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [31:0]           perf_stall_cnt,
    output logic [31:0]           perf_ext_cnt
`endif
);

    logic core_act;
    logic force_ext;

    assign core_act = core_rd | core_wr;

    dmem_starve_ctr #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve_ctr (
        .clk       (clk),
        .reset     (reset),
        .ext_req   (ext_req),
        .core_act  (core_act),
        .ext_gnt   (ext_gnt),
        .force_ext (force_ext)
    );

    // Core wins unless it is idle or the external side has starved long enough.
    assign ext_gnt    = ext_req & (~core_act | force_ext);
    assign core_stall = core_act & ext_gnt;

    // The losing requester is fully masked so it can never touch memory.
    assign mem_rd     = ext_gnt ? ~ext_we : (core_rd & ~core_stall);
    assign mem_wr     = ext_gnt ?  ext_we : (core_wr & ~core_stall);
    assign mem_addr   = ext_gnt ? ext_addr   : core_addr;
    assign mem_wdata  = ext_gnt ? ext_wdata  : core_wdata;
    assign mem_funct3 = ext_gnt ? ext_funct3 : core_funct3;

    // The pipeline ignores this while stalled, so no masking is needed.
    assign core_rdata = mem_rdata;

    // Read return: reset wins, so a read granted in the reset cycle never returns.
    always_ff @(posedge clk) begin
        if (reset) begin
            ext_rvalid <= 1'b0;
            ext_rdata  <= '0;
        end else begin
            ext_rvalid <= ext_gnt & ~ext_we;
            if (ext_gnt && !ext_we) begin
                ext_rdata <= mem_rdata;
            end
        end
    end

`ifdef DMEM_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_cnt <= '0;
            perf_ext_cnt   <= '0;
        end else begin
            if (core_stall) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
            if (ext_gnt) begin
                perf_ext_cnt <= perf_ext_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios with literal
// expectations followed by randomized traffic against a cycle model.
// Define DMEM_ARB_PERF_EN to also exercise the performance counters.
module tb_dmem_arbiter;

    localparam int AW  = 9;
    localparam int DW  = 32;
    localparam int LIM = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          core_rd, core_wr;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdata;
    logic [2:0]    core_funct3;
    logic [DW-1:0] core_rdata;
    logic          core_stall;
    logic          ext_req, ext_we;
    logic [AW-1:0] ext_addr;
    logic [DW-1:0] ext_wdata;
    logic [2:0]    ext_funct3;
    logic          ext_gnt;
    logic [DW-1:0] ext_rdata;
    logic          ext_rvalid;
    logic          mem_rd, mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [2:0]    mem_funct3;
    logic [DW-1:0] mem_rdata;
`ifdef DMEM_ARB_PERF_EN
    logic [31:0]   perf_stall_cnt, perf_ext_cnt;
`endif

    always #5 clk = ~clk;

    dmem_arbiter #(.DM_ADDRESS(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .reset(reset),
        .core_rd(core_rd), .core_wr(core_wr), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_funct3(core_funct3),
        .core_rdata(core_rdata), .core_stall(core_stall),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr),
        .ext_wdata(ext_wdata), .ext_funct3(ext_funct3),
        .ext_gnt(ext_gnt), .ext_rdata(ext_rdata), .ext_rvalid(ext_rvalid),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_funct3(mem_funct3), .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_PERF_EN
        , .perf_stall_cnt(perf_stall_cnt), .perf_ext_cnt(perf_ext_cnt)
`endif
    );

    // Data memory stand-in: combinational read, write at the clock edge.
    logic [DW-1:0] dm [0:(1<<AW)-1];
    assign mem_rdata = dm[mem_addr];
    always @(posedge clk) if (mem_wr) dm[mem_addr] <= mem_wdata;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Cycle model: number of consecutive cycles the pending request has lost,
    // the pending read return, and event totals.
    int            m_lost = 0;
    logic          m_rvalid = 1'b0;
    logic [DW-1:0] m_rdata = '0;
    logic [31:0]   m_stalls = '0;
    logic [31:0]   m_gnts = '0;

    // Protocol monitor state.
    logic          p_hold = 1'b0;
    logic          p_we;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_wdata;
    logic [2:0]    p_f3;

    always @(negedge clk) begin : cmp
        logic          act, gnt, stall, erd, ewr;
        logic [AW-1:0] eaddr;
        if (chk_en) begin
            act   = core_rd | core_wr;
            gnt   = ext_req && (!act || m_lost >= LIM);
            stall = act && gnt;
            erd   = gnt ? !ext_we : (core_rd && !stall);
            ewr   = gnt ?  ext_we : (core_wr && !stall);
            eaddr = gnt ? ext_addr : core_addr;
            check("m_ext_gnt",    ext_gnt,    gnt);
            check("m_core_stall", core_stall, stall);
            check("m_mem_rd",     mem_rd,     erd);
            check("m_mem_wr",     mem_wr,     ewr);
            check("m_mem_addr",   mem_addr,   eaddr);
            check("m_mem_wdata",  mem_wdata,  gnt ? ext_wdata : core_wdata);
            check("m_mem_funct3", mem_funct3, gnt ? ext_funct3 : core_funct3);
            check("m_core_rdata", core_rdata, dm[eaddr]);
            check("m_ext_rvalid", ext_rvalid, m_rvalid);
            check("m_ext_rdata",  ext_rdata,  m_rdata);
`ifdef DMEM_ARB_PERF_EN
            check("m_perf_stall", perf_stall_cnt, m_stalls);
            check("m_perf_ext",   perf_ext_cnt,   m_gnts);
`endif
            assert (!(p_hold && (ext_we != p_we || ext_addr != p_addr ||
                                 ext_wdata != p_wdata || ext_funct3 != p_f3)))
                else $error("ext_* changed while a request was waiting");
            p_hold  = ext_req && !ext_gnt;
            p_we    = ext_we;
            p_addr  = ext_addr;
            p_wdata = ext_wdata;
            p_f3    = ext_funct3;
            // Advance the model to the state after the coming edge.
            if (reset) begin
                m_lost   = 0;
                m_rvalid = 1'b0;
                m_rdata  = '0;
                m_stalls = '0;
                m_gnts   = '0;
            end else begin
                m_rvalid = gnt && !ext_we;
                if (m_rvalid) m_rdata = dm[ext_addr];
                if (!ext_req || gnt) m_lost = 0;
                else if (act)        m_lost = m_lost + 1;
                if (stall) m_stalls = m_stalls + 1;
                if (gnt)   m_gnts   = m_gnts + 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic ext_set(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        ext_req = 1'b1; ext_we = we; ext_addr = a; ext_wdata = d; ext_funct3 = 3'b010;
    endtask

    // Core keeps storing to 0x020 while an ext read of 0x010 waits: four lost
    // cycles, then a forced grant that stalls the core.
    task automatic starve_run();
        core_wr = 1'b1; core_addr = 9'h020; core_wdata = $urandom;
        ext_set(1'b0, 9'h010, 32'h0);
        for (int i = 0; i < LIM; i++) begin
            neg();
            check("starve_gnt_lo",   ext_gnt,    1'b0);
            check("starve_stall_lo", core_stall, 1'b0);
            check("starve_core_wr",  mem_wr,     1'b1);
            tick();
        end
        neg();
        check("starve_gnt_hi",   ext_gnt,    1'b1);
        check("starve_stall_hi", core_stall, 1'b1);
        check("starve_wr_masked", mem_wr,    1'b0);
        check("starve_ext_rd",   mem_rd,     1'b1);
        tick();
    endtask

    initial begin
        bit pend;
        int r;
        reset = 1'b1;
        core_rd = 1'b0; core_wr = 1'b0; core_addr = '0; core_wdata = '0; core_funct3 = 3'b010;
        ext_req = 1'b0; ext_we = 1'b0; ext_addr = '0; ext_wdata = '0; ext_funct3 = 3'b010;
        tick();
        chk_en = 1'b1;
        tick();
        reset = 1'b0;

        // Reset state.
        neg();
        check("rst_rvalid", ext_rvalid, 1'b0);
        check("rst_rdata",  ext_rdata,  32'h0);
        check("rst_gnt",    ext_gnt,    1'b0);
        check("rst_stall",  core_stall, 1'b0);
        check("rst_mem_wr", mem_wr,     1'b0);

        // Preload 0x010 through the external port, then read it back.
        tick(); ext_set(1'b1, 9'h010, 32'hDEADBEEF);
        neg();  check("pre_wr_gnt", ext_gnt, 1'b1);
        tick(); ext_set(1'b0, 9'h010, 32'h0);
        neg();
        check("rd_gnt",   ext_gnt,    1'b1);
        check("rd_stall", core_stall, 1'b0);
        check("rd_memrd", mem_rd,     1'b1);
        tick(); ext_req = 1'b0;
        neg();
        check("rd_rvalid", ext_rvalid, 1'b1);
        check("rd_rdata",  ext_rdata,  32'hDEADBEEF);
        tick();
        neg();
        check("rd_rvalid_pulse", ext_rvalid, 1'b0);
        check("rd_rdata_hold",   ext_rdata,  32'hDEADBEEF);

        // Write then read 0x030; no rvalid after the write.
        tick(); ext_set(1'b1, 9'h030, 32'h12345678);
        neg();  check("wr30_gnt", ext_gnt, 1'b1);
        tick(); ext_set(1'b0, 9'h030, 32'h0);
        neg();  check("wr30_no_rvalid", ext_rvalid, 1'b0);
        tick(); ext_req = 1'b0;
        neg();
        check("rd30_rvalid", ext_rvalid, 1'b1);
        check("rd30_rdata",  ext_rdata,  32'h12345678);

        // Core load wins over an ext write with no starvation; write lands when core goes idle.
        tick(); core_rd = 1'b1; core_addr = 9'h004; ext_set(1'b1, 9'h008, 32'h55);
        neg();
        check("coll_gnt",   ext_gnt,  1'b0);
        check("coll_memwr", mem_wr,   1'b0);
        check("coll_memrd", mem_rd,   1'b1);
        check("coll_addr",  mem_addr, 9'h004);
        tick(); core_rd = 1'b0;
        neg();
        check("coll_late_gnt", ext_gnt,  1'b1);
        check("coll_late_wr",  mem_wr,   1'b1);
        check("coll_late_adr", mem_addr, 9'h008);
        tick(); ext_set(1'b0, 9'h008, 32'h0);
        tick(); ext_req = 1'b0;
        neg();  check("coll_readback", ext_rdata, 32'h55);

        // Reset in the cycle after a read grant drops the return.
        tick(); ext_set(1'b0, 9'h030, 32'h0);
        tick(); ext_req = 1'b0; reset = 1'b1;
        tick(); reset = 1'b0;
        neg();
        check("rst_after_gnt_rvalid", ext_rvalid, 1'b0);
        check("rst_after_gnt_rdata",  ext_rdata,  32'h0);

        // A grant made in the reset cycle returns nothing.
        tick(); reset = 1'b1; ext_set(1'b0, 9'h010, 32'h0);
        neg();  check("rst_cycle_gnt", ext_gnt, 1'b1);
        tick(); reset = 1'b0; ext_req = 1'b0;
        neg();
        check("rst_cycle_rvalid", ext_rvalid, 1'b0);
        check("rst_cycle_rdata",  ext_rdata,  32'h0);

        // Starvation twice back-to-back: the grant itself must clear the count.
        tick();
        starve_run();
        starve_run();
        ext_req = 1'b0;
        neg();
        check("starve_stall_after", core_stall, 1'b0);
        check("starve_rdata",       ext_rdata,  32'hDEADBEEF);
`ifdef DMEM_ARB_PERF_EN
        check("perf_stall_2", perf_stall_cnt, 32'd2);
        check("perf_ext_2",   perf_ext_cnt,   32'd2);
`endif

        // Randomized traffic; core is busy most cycles so forced grants occur.
        pend = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            tick();
            reset = ($urandom_range(0, 149) == 0);
            r = $urandom_range(0, 9);
            core_rd     = (r < 4);
            core_wr     = (r >= 4) && (r < 8);
            core_addr   = AW'($urandom);
            core_wdata  = $urandom;
            core_funct3 = 3'($urandom);
            if (!pend) begin
                if ($urandom_range(0, 2) == 0) begin
                    pend = 1'b1;
                    ext_req = 1'b1;
                    ext_we = 1'($urandom);
                    ext_addr = AW'($urandom);
                    ext_wdata = $urandom;
                    ext_funct3 = 3'($urandom);
                end else begin
                    ext_req = 1'b0;
                end
            end
            neg();
            if (pend && ext_gnt) pend = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory port between the pipeline MEM stage (core) and an external requester (debug/loader/bench DMA).
- Sits between the EX/MEM pipeline register outputs and datamemory.
- Core has priority. A starvation counter forces an external grant after STARVE_LIMIT consecutive lost cycles; the pipeline is stalled for that cycle.
- External reads return registered data one cycle after grant.

Parameters:
- DM_ADDRESS, 9, data-memory address width
- DATA_W, 32, data width
- STARVE_LIMIT, 4, consecutive external-request cycles lost to the core before a forced external grant (legal range 1..255)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- core_rd  in  1  MEM-stage read enable
- core_wr  in  1  MEM-stage write enable
- core_addr  in  DM_ADDRESS  MEM-stage address
- core_wdata  in  DATA_W  MEM-stage store data
- core_funct3  in  3  access size/sign
- core_rdata  out  DATA_W  load data to MEM/WB (combinational from mem_rdata)
- core_stall  out  1  freezes PC, IF/ID, ID/EX, EX/MEM; inserts bubble into MEM/WB
- ext_req  in  1  external request, held until ext_gnt
- ext_we  in  1  1 = write, 0 = read
- ext_addr  in  DM_ADDRESS  external address
- ext_wdata  in  DATA_W  external write data
- ext_funct3  in  3  external access size
- ext_gnt  out  1  one-cycle grant; access performed this cycle
- ext_rdata  out  DATA_W  registered read data
- ext_rvalid  out  1  pulses the cycle after a granted read
- mem_rd  out  1  to datamemory
- mem_wr  out  1  to datamemory
- mem_addr  out  DM_ADDRESS  to datamemory
- mem_wdata  out  DATA_W  to datamemory
- mem_funct3  out  3  to datamemory
- mem_rdata  in  DATA_W  combinational read data from datamemory

Behaviour:
- core_act = core_rd | core_wr.
- Grant, combinational per cycle:
  - ext_gnt = ext_req & (~core_act | starve_cnt == STARVE_LIMIT).
  - core_stall = core_act & ext_gnt.
  - Memory mux selects ext when ext_gnt, else core.
  - mem_rd = ext_gnt ? ~ext_we : core_rd & ~core_stall.
  - mem_wr = ext_gnt ? ext_we : core_wr & ~core_stall.
  - Unselected requester never reaches memory.
- starve_cnt, 8-bit register, updated at posedge:
  - clears when reset, when ext_req is 0, or when ext_gnt is 1;
  - increments when ext_req & core_act & ~ext_gnt;
  - never exceeds STARVE_LIMIT.
- FSM: ARB_CORE → ARB_FORCE when starve_cnt reaches STARVE_LIMIT; ARB_FORCE → ARB_CORE on ext_gnt. ARB_FORCE is the state in which core_stall may assert.
- Read return: on a granted read, ext_rdata <= mem_rdata and ext_rvalid <= 1 at the next edge. Otherwise ext_rvalid <= 0 and ext_rdata holds its value.
- Latency:
  - core access 0 cycles, unchanged from the direct connection;
  - ext write completes in the grant cycle;
  - ext read data is valid 1 cycle after the grant.
- Simultaneous core and ext with starve_cnt < STARVE_LIMIT: core wins, counter increments.
- Back-to-back ext requests: each grant clears the counter, so the core regains priority and at most 1 forced stall occurs per STARVE_LIMIT+1 cycles.
- core_rdata = mem_rdata always. Its value is ignored by the pipeline while stalled.
- Reset, including mid-operation: starve_cnt=0, FSM=ARB_CORE, ext_rvalid=0, ext_rdata=0. Combinational outputs follow their inputs with reset-state registers. An in-flight read is dropped, and no rvalid follows a grant made in the reset cycle.
- Changing ext_* while ext_req=1 and no grant is a protocol violation (bench asserts it).

Optional Feature:
- Macro DMEM_ARB_PERF_EN.
- Defined:
  - adds outputs perf_stall_cnt (32) and perf_ext_cnt (32);
  - perf_stall_cnt increments on each core_stall cycle;
  - perf_ext_cnt increments on each ext_gnt;
  - both clear on reset and wrap at 2^32.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Add arb_state_e {ARB_CORE, ARB_FORCE} and STARVE_CNT_W=8 to Pipe_Buf_Reg_PKG.
- One sub-module, dmem_starve_ctr: counter plus FSM, outputting force_ext.
- Grant and mux logic stay in the top module.

Test Plan:
- Core idle, ext read addr 0x010 holding 0xDEADBEEF → ext_gnt same cycle; ext_rvalid=1 with ext_rdata=0xDEADBEEF next cycle; core_stall=0.
- Core store to addr 0x020 each cycle, ext_req read held → 4 cycles of core access (starve_cnt 0→4), 5th cycle ext_gnt=1 and core_stall=1, starve_cnt returns to 0.
- Core load addr 0x004 and ext write 0x55 to 0x008 in the same cycle with starve_cnt=0 → core reads, no ext_gnt, mem_wr=0; ext write lands when the core goes idle.
- Ext write 0x12345678 to 0x030 then ext read 0x030 → rdata 0x12345678; no rvalid after the write.
- Reset asserted in the cycle after an ext read grant → ext_rvalid=0, starve_cnt=0 next cycle.
- With DMEM_ARB_PERF_EN, the starvation scenario repeated twice → perf_stall_cnt=2, perf_ext_cnt=2.
